// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
// The package is combinational only, so it adds no latency and has no backpressure.
package bcd_timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Any nibble above 9 is not a BCD digit, so it saturates to 9.
  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and count bundle for bcd_countdown_timer.
// There is no latency or backpressure here; the master drives controls and the slave returns registered count/status.
interface bcd_countdown_timer_if;
  import bcd_timer_pkg::*;

  logic                 tick;
  logic                 load;
  logic [2*BCD_W-1:0]   load_val;
  logic                 start;
  logic                 pause;
  logic [BCD_W-1:0]     tens;
  logic [BCD_W-1:0]     ones;
  logic                 running;
  logic                 done;

  modport master (
    output tick, load, load_val, start, pause,
    input  tens, ones, running, done
  );

  modport slave (
    input  tick, load, load_val, start, pause,
    output tens, ones, running, done
  );

endinterface

// File: rtl/bcd_countdown_timer_digit.sv
// Single BCD digit down-counter (9..0 wrap) with a synchronous load and a combinational borrow-out.
// Its state changes one edge after en/ld, and it has no backpressure.
module mod_10_down_counter
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld,
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q,
  output logic             bo
);

  assign bo = en & (q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (en) begin
      q <= (q == '0) ? DIGIT_MAX : q - BCD_W'(1);
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with load/start/pause control and a one-cycle done pulse when it reaches 00.
// Outputs change one edge after the qualifying input, and it has no backpressure.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_countdown_timer_if.slave   bus
);

  state_t           state_q;
  state_t           state_d;
  logic             dec_en;
  logic             done_q;
  logic             ones_bo;
  logic             tens_bo;
  logic [BCD_W-1:0] ones_q;
  logic [BCD_W-1:0] tens_q;
  logic             count_zero;
  logic             count_one;

  assign count_zero = (tens_q == '0) && (ones_q == '0);
  assign count_one  = (tens_q == '0) && (ones_q == BCD_W'(1));

  // Each input in priority order (load, start, pause, tick) masks everything below it, even when it has no effect in the current state.
  always_comb begin
    state_d = state_q;
    dec_en  = 1'b0;
    if (bus.load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) state_d = count_zero ? DONE : RUN;
        end
        RUN: begin
          if (!bus.start) begin
            if (bus.pause) begin
              state_d = PAUSE;
            end else if (bus.tick && !count_zero) begin
              dec_en = 1'b1;
              if (count_one) state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE) && (state_q != DONE);
    end
  end

  mod_10_down_counter u_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (dec_en),
    .ld    (bus.load),
    .d     (clamp_digit(bus.load_val[BCD_W-1:0])),
    .q     (ones_q),
    .bo    (ones_bo)
  );

  mod_10_down_counter u_tens (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ones_bo & (state_q == RUN)),
    .ld    (bus.load),
    .d     (clamp_digit(bus.load_val[2*BCD_W-1:BCD_W])),
    .q     (tens_q),
    .bo    (tens_bo)
  );

  // The tens borrow is never consumed: the count stops at 00 and never wraps.
  logic unused_tens_bo;
  assign unused_tens_bo = tens_bo;

  assign bus.tens    = tens_q;
  assign bus.ones    = ones_q;
  assign bus.running = (state_q == RUN);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios, then random control traffic, all against a decimal-count reference model.
module tb_bcd_countdown_timer;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the count is a plain integer 0..99; the mode is a small integer code.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_cnt  = 0;
  int m_mode = M_IDLE;
  bit m_done = 1'b0;

  function automatic int sat9(input int x);
    return (x > 9) ? 9 : x;
  endfunction

  task automatic model_step(input bit l, input logic [7:0] lv, input bit s, input bit p, input bit t);
    m_done = 1'b0;
    if (l) begin
      m_cnt  = sat9(int'(lv[7:4])) * 10 + sat9(int'(lv[3:0]));
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      if (s) begin
        if (m_cnt != 0) m_mode = M_RUN;
        else begin m_mode = M_DONE; m_done = 1'b1; end
      end
    end else if (m_mode == M_RUN) begin
      if (s) begin
        m_mode = M_RUN;
      end else if (p) begin
        m_mode = M_PAUSE;
      end else if (t && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin m_mode = M_DONE; m_done = 1'b1; end
      end
    end else if (m_mode == M_PAUSE) begin
      if (s) m_mode = M_RUN;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tens"},    {4'd0, bus.tens},   8'(m_cnt / 10));
    check({tag, ".ones"},    {4'd0, bus.ones},   8'(m_cnt % 10));
    check({tag, ".running"}, {7'd0, bus.running}, {7'd0, (m_mode == M_RUN)});
    check({tag, ".done"},    {7'd0, bus.done},   {7'd0, m_done});
  endtask

  // Apply one cycle of controls, let the edge pass, then compare against the model.
  task automatic step(input string tag, input bit l, input logic [7:0] lv, input bit s, input bit p, input bit t);
    bus.load = l; bus.load_val = lv; bus.start = s; bus.pause = p; bus.tick = t;
    @(posedge clk);
    #1;
    model_step(l, lv, s, p, t);
    check_all(tag);
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
  endtask

  initial begin
    bit l, s, p, t;
    logic [7:0] lv;

    rst_n = 1'b0;
    bus.load = 1'b0; bus.load_val = 8'h00; bus.start = 1'b0; bus.pause = 1'b0; bus.tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    step("post_reset_tick", 0, 8'h00, 0, 0, 1);

    // Full countdown from 12 through the ones borrow at 10 down to 00.
    step("s1_load", 1, 8'h12, 0, 0, 0);
    step("s1_start", 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 12; i++) step($sformatf("s1_tick%0d", i), 0, 8'h00, 0, 0, 1);
    step("s1_hold", 0, 8'h00, 0, 0, 1);

    // Pause wins over a simultaneous tick.
    step("s2_load", 1, 8'h05, 0, 0, 0);
    step("s2_start", 0, 8'h00, 1, 0, 0);
    step("s2_pause_tick", 0, 8'h00, 0, 1, 1);
    step("s2_paused_tick", 0, 8'h00, 0, 0, 1);
    step("s2_resume", 0, 8'h00, 1, 0, 0);
    step("s2_tick", 0, 8'h00, 0, 0, 1);

    // Starting at 00 goes straight to DONE with a single pulse.
    step("s3_load", 1, 8'h00, 0, 0, 0);
    step("s3_start", 0, 8'h00, 1, 0, 0);
    step("s3_start2", 0, 8'h00, 1, 0, 1);
    step("s3_tick", 0, 8'h00, 0, 1, 1);

    // Clamping, then load beating start.
    step("s4_load_af", 1, 8'hAF, 0, 0, 0);
    step("s4_load_start", 1, 8'h47, 1, 0, 0);
    step("s4_idle_tick", 0, 8'h00, 0, 1, 1);

    // Asynchronous reset in the middle of a run.
    step("s5_load", 1, 8'h37, 0, 0, 0);
    step("s5_start", 0, 8'h00, 1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    m_cnt = 0; m_mode = M_IDLE; m_done = 1'b0;
    check_all("s5_async_rst");
    @(posedge clk);
    #1;
    check_all("s5_in_rst");
    rst_n = 1'b1;
    step("s5_tick_after", 0, 8'h00, 0, 0, 1);

    // Borrow from 40 to 39.
    step("s6_load", 1, 8'h40, 0, 0, 0);
    step("s6_start", 0, 8'h00, 1, 0, 0);
    step("s6_tick", 0, 8'h00, 0, 0, 1);
    step("s6_tick2", 0, 8'h00, 0, 0, 1);

    // Random control traffic.
    for (int i = 0; i < 600; i++) begin
      l  = ($urandom_range(0, 99) < 6);
      s  = ($urandom_range(0, 9) == 0);
      p  = ($urandom_range(0, 11) == 0);
      t  = ($urandom_range(0, 2) != 0);
      lv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                       : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      step($sformatf("rand%0d", i), l, lv, s, p, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
